seg_scan_disp: RTL



---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_scan_disp_hex7seg.sv | 11 +
 rtl/seg_scan_disp.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment codes,
// blank pattern and the default digit-slot length.
package seg_pkg;

  localparam int DIV_DEF = 50000;

  // Active-low a..g codes for hex digits 0..F (index 15 leftmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] BLANK_SEG = 7'h7F;
  localparam logic [3:0] CS_OFF    = 4'hF;

endpackage

// File: rtl/seg_scan_disp_hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_disp.sv
// Four-digit multiplexed seven-segment driver; new values are taken only at
// frame boundaries so a frame never mixes old and new digits.
module seg_scan_disp
  import seg_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] Val,
  input  logic        Val_vld,
  input  logic [3:0]  Dp,
  input  logic        Blank_lz,
  output logic [7:0]  Dis,
  output logic [3:0]  Cs,
  output logic        Upd
);

  localparam int PC_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      sel_q, sel_d;
  logic [15:0]     pval_q, pval_d;
  logic [3:0]      pdp_q, pdp_d;
  logic            pend_q, pend_d;
  logic [15:0]     shown_q, shown_d;
  logic [3:0]      sdp_q, sdp_d;
  logic [7:0]      dis_q, dis_d;
  logic [3:0]      cs_q, cs_d;
  logic            upd_q, upd_d;

  logic            tick, boundary, load_now, load_pend, blank;
  logic [3:0]      nib;
  logic [6:0]      seg;

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (seg)
  );

  always_comb begin
    tick      = (pc_q == PC_W'(DIV - 1));
    boundary  = tick && (sel_q == 2'd0);
    load_now  = boundary && Val_vld;
    load_pend = boundary && !Val_vld && pend_q;

    pc_d  = tick ? '0 : pc_q + PC_W'(1);
    sel_d = tick ? sel_q + 2'd1 : sel_q;

    pval_d = pval_q;
    pdp_d  = pdp_q;
    pend_d = pend_q;
    if (boundary) begin
      pend_d = 1'b0;
    end else if (Val_vld) begin
      pval_d = Val;
      pdp_d  = Dp;
      pend_d = 1'b1;
    end

    shown_d = shown_q;
    sdp_d   = sdp_q;
    if (load_now) begin
      shown_d = Val;
      sdp_d   = Dp;
    end else if (load_pend) begin
      shown_d = pval_q;
      sdp_d   = pdp_q;
    end

    // Decode from the post-update value so a boundary tick shows new digit 0.
    nib = shown_d[{sel_q, 2'b00} +: 4];
    case (sel_q)
      2'd1:    blank = Blank_lz && (shown_d[15:4] == 12'h000);
      2'd2:    blank = Blank_lz && (shown_d[15:8] == 8'h00);
      2'd3:    blank = Blank_lz && (shown_d[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase

    dis_d = dis_q;
    cs_d  = cs_q;
    if (tick) begin
      dis_d = {~sdp_d[sel_q], blank ? BLANK_SEG : seg};
      cs_d  = ~(4'b0001 << sel_q);
    end
    upd_d = load_now || load_pend;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= '0;
      sel_q   <= 2'd0;
      pval_q  <= 16'h0000;
      pdp_q   <= 4'h0;
      pend_q  <= 1'b0;
      shown_q <= 16'h0000;
      sdp_q   <= 4'h0;
      dis_q   <= 8'hFF;
      cs_q    <= CS_OFF;
      upd_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      pval_q  <= pval_d;
      pdp_q   <= pdp_d;
      pend_q  <= pend_d;
      shown_q <= shown_d;
      sdp_q   <= sdp_d;
      dis_q   <= dis_d;
      cs_q    <= cs_d;
      upd_q   <= upd_d;
    end
  end

  assign Dis = dis_q;
  assign Cs  = cs_q;
  assign Upd = upd_q;

endmodule
